// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud-count helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_e;

    // Count value at which the centre of the start bit is reached.
    function automatic int unsigned half_bit_cnt(input int unsigned clks_per_bit);
        return clks_per_bit / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side UART bundle: serial line in, byte and status strobes out.
interface uart_rx_if;
    logic                           rx;
    logic [uart_pkg::DATA_BITS-1:0] data_out;
    logic                           data_valid;
    logic                           frame_err;
    logic                           parity_err;
    logic                           busy;

    modport master (
        input  rx,
        output data_out, data_valid, frame_err, parity_err, busy
    );

    modport slave (
        output rx,
        input  data_out, data_valid, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; presets to idle-high on reset.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_module.sv
// UART receiver, 8 data bits LSB first, 1 stop bit, centre sampling.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_rx_module
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input logic       clk,
    input logic       rst_n,
    uart_rx_if.master bus
);

    localparam int unsigned            CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned            IDX_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]       CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]       CNT_HALF = CNT_W'(half_bit_cnt(CLKS_PER_BIT));
    localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.rx),
        .q    (rx_s)
    );

    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (baud_cnt_q == CNT_HALF) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    // A high level at mid-start means the edge was a glitch.
                    state_d    = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt_q == CNT_FULL) begin
                    baud_cnt_d         = '0;
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_cnt_q == CNT_FULL) begin
                    baud_cnt_d = '0;
                    par_bad_d  = ^{shift_q, rx_s};
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_cnt_q == CNT_FULL) begin
                    baud_cnt_d = '0;
                    if (rx_s) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = par_bad_q;
`endif
                        state_d      = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                baud_cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                baud_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
    // The strobe cycle still counts as busy, so busy drops the cycle after data_valid.
    assign bus.busy = (state_q != IDLE) | data_valid_q;

endmodule

// File: tb/tb_uart_rx_module.sv
// Self-checking bench for uart_rx_module (CLKS_PER_BIT=16, SYNC_STAGES=2) with a frame-level model.
module tb_uart_rx_module;
    localparam int unsigned BIT  = 16;
    localparam int unsigned SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NBITS = 10;
`else
    localparam int unsigned NBITS = 9;
`endif
    localparam int EXP_LAT = SYNC + BIT / 2 + NBITS * BIT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if u_if ();

    uart_rx_module #(
        .CLKS_PER_BIT(BIT),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if)
    );

    int checks = 0;
    int errors = 0;

    // Monitor: collects everything the DUT reports.
    int         cyc = 0;
    logic [7:0] got_bytes[$];
    logic       got_perr[$];
    int         ferr_cnt = 0;
    int         dv_long = 0;
    int         fe_long = 0;
    int         dv_cyc = 0;
    logic       busy_at_dv = 1'b0;
    logic       busy_after_dv = 1'b1;
    logic       prev_dv = 1'b0;
    logic       prev_fe = 1'b0;

    // Reference model: expected reported results.
    logic [7:0] exp_bytes[$];
    logic       exp_perr[$];
    int         exp_ferr = 0;
    logic [7:0] last_good = 8'h00;
    int         fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.data_valid) begin
            got_bytes.push_back(u_if.data_out);
            got_perr.push_back(u_if.parity_err);
            dv_cyc     = cyc;
            busy_at_dv = u_if.busy;
        end
        if (prev_dv) busy_after_dv = u_if.busy;
        if (u_if.data_valid && prev_dv) dv_long++;
        if (u_if.frame_err) ferr_cnt++;
        if (u_if.frame_err && prev_fe) fe_long++;
        prev_dv = u_if.data_valid;
        prev_fe = u_if.frame_err;
    end

    task automatic clear_all();
        got_bytes.delete();
        got_perr.delete();
        exp_bytes.delete();
        exp_perr.delete();
        ferr_cnt = 0;
        exp_ferr = 0;
    endtask

    task automatic hold(input logic b, input int n);
        u_if.rx = b;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame and record the expected outcome from frame-level rules.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pbit);
        fall_cyc = cyc;
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(b[i], BIT);
`ifdef UART_RX_PARITY_EN
        hold(pbit, BIT);
`endif
        hold(stop, BIT);
        u_if.rx = 1'b1;
        if (stop) begin
            exp_bytes.push_back(b);
`ifdef UART_RX_PARITY_EN
            exp_perr.push_back((^b) ^ pbit);
`else
            exp_perr.push_back(1'b0);
`endif
            last_good = b;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic compare_results(input string name);
        checks++;
        if (got_bytes.size() != exp_bytes.size()) begin
            errors++;
            $display("FAIL %s count: got %0d expected %0d", name, got_bytes.size(),
                     exp_bytes.size());
        end else begin
            for (int i = 0; i < exp_bytes.size(); i++) begin
                checks++;
                if (got_bytes[i] !== exp_bytes[i] || got_perr[i] !== exp_perr[i]) begin
                    errors++;
                    $display("FAIL %s byte[%0d]: got %02h/perr %0b expected %02h/perr %0b", name,
                             i, got_bytes[i], got_perr[i], exp_bytes[i], exp_perr[i]);
                end
            end
        end
        checks++;
        if (ferr_cnt !== exp_ferr) begin
            errors++;
            $display("FAIL %s frame_err: got %0d expected %0d", name, ferr_cnt, exp_ferr);
        end
        checks++;
        if (dv_long !== 0 || fe_long !== 0) begin
            errors++;
            $display("FAIL %s pulse width: got dv_long %0d fe_long %0d expected 0 0", name,
                     dv_long, fe_long);
        end
        checks++;
        if (u_if.data_out !== last_good) begin
            errors++;
            $display("FAIL %s data_out held: got %02h expected %02h", name, u_if.data_out,
                     last_good);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        u_if.rx = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            u_if.rx = 1'($urandom_range(0, 1));
        end
        checks++;
        if ({u_if.data_out, u_if.data_valid, u_if.frame_err, u_if.parity_err, u_if.busy} !== 12'h0)
        begin
            errors++;
            $display("FAIL reset outputs: got %02h dv%0b fe%0b pe%0b busy%0b expected all 0",
                     u_if.data_out, u_if.data_valid, u_if.frame_err, u_if.parity_err, u_if.busy);
        end
        u_if.rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        checks++;
        if (u_if.busy !== 1'b0 || got_bytes.size() != 0 || ferr_cnt != 0) begin
            errors++;
            $display("FAIL reset idle: got busy %0b bytes %0d ferr %0d expected 0 0 0",
                     u_if.busy, got_bytes.size(), ferr_cnt);
        end
    endtask

    task automatic test_good_frame();
        clear_all();
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        compare_results("good_a5");
        checks++;
        if (busy_at_dv !== 1'b1 || busy_after_dv !== 1'b0) begin
            errors++;
            $display("FAIL busy_fall: got at_dv %0b after_dv %0b expected 1 0", busy_at_dv,
                     busy_after_dv);
        end
        checks++;
        if (dv_cyc - fall_cyc < EXP_LAT - 1 || dv_cyc - fall_cyc > EXP_LAT + 1) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d +/-1", dv_cyc - fall_cyc, EXP_LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        clear_all();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, ^b);
        end
        repeat (2 * BIT) @(negedge clk);
        compare_results("back_to_back");
    endtask

    task automatic test_glitch();
        int   n = 0;
        logic saw_busy = 1'b0;
        clear_all();
        u_if.rx = 1'b0;
        repeat (5) begin
            @(negedge clk);
            saw_busy |= u_if.busy;
        end
        u_if.rx = 1'b1;
        while (u_if.busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (saw_busy !== 1'b1 || u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch busy: got saw %0b final %0b expected 1 0", saw_busy, u_if.busy);
        end
        repeat (2 * BIT) @(negedge clk);
        compare_results("glitch");
    endtask

    task automatic test_break();
        clear_all();
        hold(1'b0, 15 * BIT);
        exp_ferr = 1;
        checks++;
        if (u_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL break busy low: got %0b expected 1", u_if.busy);
        end
        u_if.rx = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL break busy release: got %0b expected 0", u_if.busy);
        end
        compare_results("break");
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_all();
        send_frame(8'h03, 1'b1, 1'b1);
        send_frame(8'h03, 1'b1, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        checks++;
        if (got_perr.size() != 2 || got_perr[0] !== 1'b1 || got_perr[1] !== 1'b0) begin
            errors++;
            $display("FAIL parity: got %0d flags %p expected 2 flags 1,0", got_perr.size(),
                     got_perr);
        end
        compare_results("parity");
    endtask
`endif

    task automatic test_random();
        logic [7:0] b;
        logic       stop;
        clear_all();
        for (int i = 0; i < 16; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop, 1'($urandom_range(0, 1)));
            if (!stop) repeat (2 * BIT) @(negedge clk);
            else repeat ($urandom_range(0, BIT - 1)) @(negedge clk);
        end
        repeat (2 * BIT) @(negedge clk);
        compare_results("random");
    endtask

    initial begin
        u_if.rx = 1'b1;
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_glitch();
        test_break();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
